ras_ctrl: RTL and testbench
===========================

Name: ras_ctrl

Overview:
- Return address stack for the BPU.
- Consumes the `bpu_update_t` feedback stream produced at branch resolution; this block is the receiving end of that update interface.
- Holds a speculative stack, pushed and popped at fetch-time prediction, and a committed stack, updated from resolved feedback.
- On any feedback flush, the speculative stack is restored from the committed stack.
- Supplies the predicted return target to the NPC mux.

Parameters:
- DEPTH, 8, number of stack entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- pred_valid_i  input  1  fetch-side prediction valid this cycle.
- pred_br_type_i  input  2  predicted type (`_CALL`/`_RETURN`/`_ABSOLUTE`/`_PC_RELATIVE` from bpu.svh).
- pred_pc_i  input  30  word PC of the predicted branch ([31:2]).
- update_i  input  bpu_update_t  resolved feedback (flush, br_taken, pc, br_type, bht_update, …).
- ras_target_o  output  30  speculative top-of-stack word address.
- ras_valid_o  output  1  speculative stack non-empty.
- ras_full_o  output  1  speculative count == DEPTH (debug/perf).

Behaviour:
- State:
  - spec_stk[DEPTH], spec_ptr, spec_cnt (0..DEPTH).
  - cmt_stk[DEPTH], cmt_ptr, cmt_cnt.
  - Pointers index the current top entry.
- Reset (async, rst_n=0): all entries 0, pointers 0, counts 0, so ras_target_o=0, ras_valid_o=0, ras_full_o=0. Reset mid-operation discards all contents immediately.
- Outputs are combinational from registered speculative state:
  - ras_target_o = spec_stk[spec_ptr].
  - ras_valid_o = spec_cnt != 0.
  - ras_full_o = spec_cnt == DEPTH.
- Push (stack X, return address A):
  - ptr ← ptr+1 mod DEPTH (wraps); stk[new ptr] ← A.
  - cnt ← min(cnt+1, DEPTH).
  - When full, the oldest entry is silently overwritten.
- Pop:
  - If cnt != 0: ptr ← ptr−1 mod DEPTH, cnt ← cnt−1.
  - If cnt == 0: no change (underflow ignored). Entry contents are never cleared on pop.
- Return address is always PC+1 in word units (pred_pc_i+1 or update_i.pc+1), i.e. byte PC+4. Arithmetic is 30-bit, modulo 2^30.
- Commit event: update_i.bht_update && update_i.br_taken.
  - br_type == `_CALL`: push cmt with update_i.pc+1.
  - br_type == `_RETURN`: pop cmt.
  - Other types: no commit-stack change.
  - Applied regardless of flush.
- Speculative event (only when update_i.flush == 0): pred_valid_i.
  - `_CALL`: push spec with pred_pc_i+1.
  - `_RETURN`: pop spec.
  - Other types: none.
- Flush (update_i.flush == 1):
  - spec_stk/spec_ptr/spec_cnt ← next-state value of the cmt stack, including the same-cycle commit event.
  - pred_valid_i in that cycle is ignored.
- Latency: one cycle. Push/pop/restore become visible on ras_* the cycle after the event.
- Simultaneous spec push and flush: flush wins.
- Simultaneous commit and spec events without flush: both stacks update independently in the same cycle.
- No handshake back-pressure. The block is always ready; stall qualification is the producer's responsibility.

Decomposition:
- bpu.svh / bpu package holds: `bpu_update_t`, `_CALL`/`_RETURN`/`_ABSOLUTE`/`_PC_RELATIVE`, and a new `ras_entry_t` (30-bit word address).
- Natural sub-module: ras_stack (one circular stack: push/pop/load ports, data/ptr/cnt outputs). Instantiated twice, spec and commit.
  - The commit instance's next-state outputs feed the spec instance's load port.
- Total RTL: ~150–250 lines.

Test Plan:
- Reset → ras_valid_o=0, ras_target_o=0. Then spec `_CALL` at pred_pc_i=0x100 → next cycle ras_target_o=0x101, ras_valid_o=1.
- Spec CALLs at 0x10, 0x20 then one `_RETURN` → ras_target_o=0x11, spec_cnt=1. A second RETURN → ras_valid_o=0. A third RETURN → no change, still ras_valid_o=0.
- DEPTH+1 (9) CALLs at pred_pc 0x0..0x8 → ras_full_o=1, top 0x9. Nine pops yield targets 0x9..0x2 then empty; 0x1 is lost to wrap.
- Commit CALL pc=0x40 (bht_update=1, br_taken=1), then spec CALLs 0x50, 0x60 → top 0x61. Then flush=1 with no commit event → next cycle ras_target_o=0x41, ras_valid_o=1.
- Same cycle: flush=1, commit `_CALL` pc=0x80, pred_valid_i=1 `_CALL` pc=0x90 → next cycle ras_target_o=0x81; the spec push is ignored.
- Commit `_RETURN` with br_taken=0, or bht_update=0 → commit stack unchanged. Verify with a subsequent flush restoring the prior top.

Source files
------------

// File: rtl/ras_ctrl_pkg.sv
// rtl/ras_ctrl_pkg.sv - BPU feedback types and return-address-stack entry type
package ras_ctrl_pkg;

  // Branch type encoding shared by prediction and resolution paths
  typedef enum logic [1:0] {
    BR_ABSOLUTE    = 2'd0,
    BR_PC_RELATIVE = 2'd1,
    BR_CALL        = 2'd2,
    BR_RETURN      = 2'd3
  } br_type_t;

  // One stack entry: a 30-bit word address (byte address [31:2])
  typedef logic [29:0] ras_entry_t;

  // Resolved-branch feedback stream from the execute stage
  typedef struct packed {
    logic       flush;
    logic       br_taken;
    logic       bht_update;
    br_type_t   br_type;
    ras_entry_t pc;
  } bpu_update_t;

  // Return address of a call at word PC pc: the next sequential word
  function automatic ras_entry_t ret_addr(input ras_entry_t pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/ras_ctrl_stack.sv
// rtl/ras_ctrl_stack.sv - one circular return-address stack with push/pop/load
module ras_ctrl_stack
  import ras_ctrl_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  ras_entry_t                  push_data_i,
  input  logic                        load_i,
  input  ras_entry_t [DEPTH-1:0]      load_stk_i,
  input  logic       [PTR_W-1:0]      load_ptr_i,
  input  logic       [CNT_W-1:0]      load_cnt_i,
  output ras_entry_t                  top_o,
  output logic       [CNT_W-1:0]      cnt_o,
  output ras_entry_t [DEPTH-1:0]      nxt_stk_o,
  output logic       [PTR_W-1:0]      nxt_ptr_o,
  output logic       [CNT_W-1:0]      nxt_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  ras_entry_t [DEPTH-1:0] stk_q, stk_d;
  logic       [PTR_W-1:0] ptr_q, ptr_d;
  logic       [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: load overrides everything; push wraps and overwrites the oldest
  // entry when full; pop on an empty stack is ignored and never clears data
  always_comb begin
    stk_d = stk_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      stk_d = load_stk_i;
      ptr_d = load_ptr_i;
      cnt_d = load_cnt_i;
    end else if (push_i) begin
      ptr_d        = ptr_q + PTR_W'(1);
      stk_d[ptr_d] = push_data_i;
      cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers, cleared immediately by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      stk_q <= stk_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign top_o     = stk_q[ptr_q];
  assign cnt_o     = cnt_q;
  assign nxt_stk_o = stk_d;
  assign nxt_ptr_o = ptr_d;
  assign nxt_cnt_o = cnt_d;

endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - speculative and committed return address stacks for the BPU
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_valid_i,
  input  logic [1:0]  pred_br_type_i,
  input  logic [29:0] pred_pc_i,
  input  bpu_update_t update_i,
  output logic [29:0] ras_target_o,
  output logic        ras_valid_o,
  output logic        ras_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic commit_ev, cmt_push, cmt_pop, spec_push, spec_pop;

  ras_entry_t [DEPTH-1:0] cmt_nxt_stk, spec_nxt_stk;
  logic       [PTR_W-1:0] cmt_nxt_ptr, spec_nxt_ptr;
  logic       [CNT_W-1:0] cmt_nxt_cnt, spec_nxt_cnt;
  logic       [CNT_W-1:0] cmt_cnt, spec_cnt;
  ras_entry_t             cmt_top, spec_top;

  // Committed stack follows taken, resolved calls/returns even during a flush;
  // the speculative stack follows predictions only when no flush is in flight
  always_comb begin
    commit_ev = update_i.bht_update && update_i.br_taken;
    cmt_push  = commit_ev && (update_i.br_type == BR_CALL);
    cmt_pop   = commit_ev && (update_i.br_type == BR_RETURN);
    spec_push = !update_i.flush && pred_valid_i && (pred_br_type_i == BR_CALL);
    spec_pop  = !update_i.flush && pred_valid_i && (pred_br_type_i == BR_RETURN);
  end

  ras_ctrl_stack #(.DEPTH(DEPTH)) u_cmt (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmt_push),
    .pop_i       (cmt_pop),
    .push_data_i (ret_addr(update_i.pc)),
    .load_i      (1'b0),
    .load_stk_i  ('0),
    .load_ptr_i  ('0),
    .load_cnt_i  ('0),
    .top_o       (cmt_top),
    .cnt_o       (cmt_cnt),
    .nxt_stk_o   (cmt_nxt_stk),
    .nxt_ptr_o   (cmt_nxt_ptr),
    .nxt_cnt_o   (cmt_nxt_cnt)
  );

  // A flush reloads the speculative stack from the committed stack's next
  // state, so a commit in the same cycle is already reflected
  ras_ctrl_stack #(.DEPTH(DEPTH)) u_spec (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (spec_push),
    .pop_i       (spec_pop),
    .push_data_i (ret_addr(pred_pc_i)),
    .load_i      (update_i.flush),
    .load_stk_i  (cmt_nxt_stk),
    .load_ptr_i  (cmt_nxt_ptr),
    .load_cnt_i  (cmt_nxt_cnt),
    .top_o       (spec_top),
    .cnt_o       (spec_cnt),
    .nxt_stk_o   (spec_nxt_stk),
    .nxt_ptr_o   (spec_nxt_ptr),
    .nxt_cnt_o   (spec_nxt_cnt)
  );

  // Committed-stack outputs and speculative next state have no consumer here
  logic unused_sig;
  assign unused_sig = ^{cmt_top, cmt_cnt, spec_nxt_stk, spec_nxt_ptr, spec_nxt_cnt};

  assign ras_target_o = spec_top;
  assign ras_valid_o  = (spec_cnt != '0);
  assign ras_full_o   = (spec_cnt == CNT_MAX);

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - self-checking bench for ras_ctrl against a behavioural model
module tb_ras_ctrl;
  import ras_ctrl_pkg::*;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid;
  logic [1:0]  pred_type;
  logic [29:0] pred_pc;
  bpu_update_t upd;
  logic [29:0] ras_target;
  logic        ras_valid;
  logic        ras_full;

  int tests = 0;
  int fails = 0;

  // Model: each stack is an array with a top index and an occupancy count
  logic [29:0] sm [D];
  logic [29:0] cm [D];
  int sp, sn, cp, cn;

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid_i   (pred_valid),
    .pred_br_type_i (pred_type),
    .pred_pc_i      (pred_pc),
    .update_i       (upd),
    .ras_target_o   (ras_target),
    .ras_valid_o    (ras_valid),
    .ras_full_o     (ras_full)
  );

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin
      sm[i] = '0;
      cm[i] = '0;
    end
    sp = 0; sn = 0; cp = 0; cn = 0;
  endtask

  task automatic m_step();
    logic [29:0] a;
    if (upd.bht_update && upd.br_taken) begin
      if (upd.br_type == BR_CALL) begin
        a = upd.pc + 30'd1;
        cp = (cp + 1) % D;
        cm[cp] = a;
        cn = (cn < D) ? cn + 1 : D;
      end else if (upd.br_type == BR_RETURN && cn > 0) begin
        cp = (cp + D - 1) % D;
        cn = cn - 1;
      end
    end
    if (upd.flush) begin
      for (int i = 0; i < D; i++) sm[i] = cm[i];
      sp = cp;
      sn = cn;
    end else if (pred_valid) begin
      if (pred_type == 2'(BR_CALL)) begin
        a = pred_pc + 30'd1;
        sp = (sp + 1) % D;
        sm[sp] = a;
        sn = (sn < D) ? sn + 1 : D;
      end else if (pred_type == 2'(BR_RETURN) && sn > 0) begin
        sp = (sp + D - 1) % D;
        sn = sn - 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("model_target", {2'b0, ras_target}, {2'b0, sm[sp]});
    check("model_valid", {31'b0, ras_valid}, {31'b0, sn != 0});
    check("model_full", {31'b0, ras_full}, {31'b0, sn == D});
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    pred_type  = 2'd0;
    pred_pc    = '0;
    upd        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic spec(input br_type_t t, input logic [29:0] pc);
    idle();
    pred_valid = 1'b1;
    pred_type  = 2'(t);
    pred_pc    = pc;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_target", {2'b0, ras_target}, 32'h0);
    check("reset_valid", {31'b0, ras_valid}, 32'h0);
    rst_n = 1'b1;

    // Single call
    spec(BR_CALL, 30'h100);
    check("call_target", {2'b0, ras_target}, 32'h101);
    check("call_valid", {31'b0, ras_valid}, 32'h1);

    // Calls then returns, including underflow
    @(negedge clk);
    do_reset();
    spec(BR_CALL, 30'h10);
    spec(BR_CALL, 30'h20);
    check("two_calls", {2'b0, ras_target}, 32'h21);
    spec(BR_RETURN, 30'h0);
    check("ret1_target", {2'b0, ras_target}, 32'h11);
    check("ret1_valid", {31'b0, ras_valid}, 32'h1);
    spec(BR_RETURN, 30'h0);
    check("ret2_valid", {31'b0, ras_valid}, 32'h0);
    spec(BR_RETURN, 30'h0);
    check("ret3_valid", {31'b0, ras_valid}, 32'h0);
    check("ret3_target", {2'b0, ras_target}, 32'h0);

    // Overflow wraps and loses the oldest entry
    for (int i = 0; i <= D; i++) spec(BR_CALL, 30'(i));
    check("ovf_full", {31'b0, ras_full}, 32'h1);
    check("ovf_top", {2'b0, ras_target}, 32'h9);
    for (int k = 0; k < D; k++) begin
      spec(BR_RETURN, 30'h0);
      if (k < D - 1) check("ovf_pop_target", {2'b0, ras_target}, 32'(8 - k));
      else           check("ovf_pop_empty", {31'b0, ras_valid}, 32'h0);
    end

    // Flush restores the committed stack
    idle();
    upd.bht_update = 1'b1; upd.br_taken = 1'b1; upd.br_type = BR_CALL; upd.pc = 30'h40;
    tick();
    spec(BR_CALL, 30'h50);
    spec(BR_CALL, 30'h60);
    check("spec_top_61", {2'b0, ras_target}, 32'h61);
    idle();
    upd.flush = 1'b1;
    tick();
    check("flush_target", {2'b0, ras_target}, 32'h41);
    check("flush_valid", {31'b0, ras_valid}, 32'h1);

    // Flush with same-cycle commit wins over a spec push
    idle();
    upd.flush = 1'b1; upd.bht_update = 1'b1; upd.br_taken = 1'b1;
    upd.br_type = BR_CALL; upd.pc = 30'h80;
    pred_valid = 1'b1; pred_type = 2'(BR_CALL); pred_pc = 30'h90;
    tick();
    check("flush_commit", {2'b0, ras_target}, 32'h81);

    // Non-qualifying commit returns leave the committed stack alone
    spec(BR_CALL, 30'h200);
    idle();
    upd.bht_update = 1'b1; upd.br_taken = 1'b0; upd.br_type = BR_RETURN;
    tick();
    idle();
    upd.bht_update = 1'b0; upd.br_taken = 1'b1; upd.br_type = BR_RETURN;
    tick();
    idle();
    upd.flush = 1'b1;
    tick();
    check("noncommit_ret", {2'b0, ras_target}, 32'h81);
    idle();
    upd.flush = 1'b1; upd.bht_update = 1'b1; upd.br_taken = 1'b1; upd.br_type = BR_RETURN;
    tick();
    check("commit_ret", {2'b0, ras_target}, 32'h41);

    // Address arithmetic wraps at 30 bits
    spec(BR_CALL, 30'h3FFFFFFF);
    check("pc_wrap", {2'b0, ras_target}, 32'h0);
    check("pc_wrap_valid", {31'b0, ras_valid}, 32'h1);

    // Asynchronous reset away from a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("async_rst_valid", {31'b0, ras_valid}, 32'h0);
    check("async_rst_target", {2'b0, ras_target}, 32'h0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      pred_valid = ($urandom_range(0, 3) != 0);
      pred_type  = 2'($urandom_range(0, 3));
      pred_pc    = ($urandom_range(0, 15) == 0) ? 30'h3FFFFFFF : 30'($urandom());
      upd.flush      = ($urandom_range(0, 9) == 0);
      upd.bht_update = ($urandom_range(0, 1) == 1);
      upd.br_taken   = ($urandom_range(0, 3) != 0);
      upd.br_type    = br_type_t'($urandom_range(0, 3));
      upd.pc         = 30'($urandom());
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
